// File: rtl/s2p_pkg.sv
// Shared definitions for the s2p/p2s serial link: frame width and the
// transmitter state encoding.
package s2p_pkg;

    // Default frame width; the transmitter and the receiver must agree on it.
    localparam int S2P_DW = 8;

    // Transmitter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } p2s_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset and first-word
// fall-through read data (rdata always shows the head entry).
module sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DW-1:0]                wdata,
    input  logic                         pop,
    output logic [DW-1:0]                rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // Guard against overflow/underflow so the pointers can never desynchronise.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr];

    // Storage array: data only, never reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/p2s_tx.sv
// Parallel-to-serial transmitter: buffers bytes in a FIFO and sends each one
// as a DW-cycle active-low frame on wra_n/da (MSB first), followed by at
// least GAP idle cycles so the receiver can cross the word into its domain.
module p2s_tx
    import s2p_pkg::*;
#(
    parameter int DW         = S2P_DW,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP        = 2
) (
    input  logic          clka,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          din_ready,
    output logic          wra_n,
    output logic          da,
    output logic          busy
);

    localparam int BW = $clog2(DW);
    localparam int GW = $clog2(GAP + 1);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (GAP < 1) begin : g_bad_gap
        $error("p2s_tx: GAP must be >= 1");
    end
    if (DW < 2) begin : g_bad_dw
        $error("p2s_tx: DW must be >= 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("p2s_tx: FIFO_DEPTH must be a power of two >= 2");
    end

    p2s_state_e    state;
    p2s_state_e    state_next;
    logic [BW-1:0] bitcnt;
    logic [GW-1:0] gapcnt;
    logic [DW-1:0] shreg;

    logic [DW-1:0] fifo_rdata;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic          push;

    logic          load;
    logic          wra_n_d;
    logic          da_d;

    // Ready comes from the registered count only, so it stays low in the
    // cycle a full FIFO pops.
    assign din_ready = !fifo_full && !rst;
    assign push      = din_valid && din_ready;
    assign busy      = (state != ST_IDLE) || (fifo_count != '0);

    sync_fifo #(
        .DW    (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clka),
        .rst   (rst),
        .push  (push),
        .wdata (din),
        .pop   (load),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // State register.
    always_ff @(posedge clka) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the last GAP cycle may start the next frame directly.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (bitcnt == '0) state_next = ST_GAP;
            end
            ST_GAP: begin
                if (gapcnt == '0) state_next = fifo_empty ? ST_IDLE : ST_SHIFT;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output decode: pop/load request and the next values of wra_n and da.
    always_comb begin
        load    = 1'b0;
        wra_n_d = 1'b1;
        da_d    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    load    = 1'b1;
                    wra_n_d = 1'b0;
                    da_d    = fifo_rdata[DW-1];
                end
            end
            ST_SHIFT: begin
                if (bitcnt != '0) begin
                    wra_n_d = 1'b0;
                    da_d    = shreg[DW-2];
                end
            end
            ST_GAP: begin
                if ((gapcnt == '0) && !fifo_empty) begin
                    load    = 1'b1;
                    wra_n_d = 1'b0;
                    da_d    = fifo_rdata[DW-1];
                end
            end
            default: begin
                load    = 1'b0;
                wra_n_d = 1'b1;
                da_d    = 1'b0;
            end
        endcase
    end

    // Registered serial outputs and frame/gap counters; reset aborts any frame.
    always_ff @(posedge clka) begin
        if (rst) begin
            wra_n  <= 1'b1;
            da     <= 1'b0;
            bitcnt <= '0;
            gapcnt <= '0;
        end else begin
            wra_n <= wra_n_d;
            da    <= da_d;
            if (load) begin
                bitcnt <= BW'(DW - 1);
            end else if ((state == ST_SHIFT) && (bitcnt != '0)) begin
                bitcnt <= bitcnt - BW'(1);
            end
            if ((state == ST_SHIFT) && (bitcnt == '0)) begin
                gapcnt <= GW'(GAP - 1);
            end else if ((state == ST_GAP) && (gapcnt != '0)) begin
                gapcnt <= gapcnt - GW'(1);
            end
        end
    end

    // Shift register: data path only, loaded from the FIFO head and shifted MSB-first.
    always_ff @(posedge clka) begin
        if (load) begin
            shreg <= fifo_rdata;
        end else if (state == ST_SHIFT) begin
            shreg <= shreg << 1;
        end
    end

endmodule
